// File: rtl/eth_fcs_rx_check.sv
// Receive FCS checker: CRC-32 residue check, 4-byte FCS holdback, per-frame status.
// Optional FCS_RX_STATS_EN adds saturating good/bad/runt frame counters.
module eth_fcs_rx_check #(
  parameter int MIN_LEN = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        frame_done,
  output logic        frame_good,
  output logic        frame_runt,
  output logic [15:0] frame_len
`ifdef FCS_RX_STATS_EN
  ,
  output logic [15:0] good_count,
  output logic [15:0] bad_count,
  output logic [15:0] runt_count
`endif
);

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY_R  = 32'hEDB8_8320;

  function automatic logic [31:0] crc_update(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
    end
    return c;
  endfunction

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t           state;
  logic [2:0]       fill;
  logic [3:0][7:0]  hold;   // hold[3] is the oldest byte once full
  logic [31:0]      crc;
  logic [15:0]      len;

  logic [31:0] crc_next;
  logic [15:0] len_next;
  logic        runt_next;

  always_comb begin
    crc_next  = crc_update(crc, in_data);
    len_next  = (len == 16'hFFFF) ? len : len + 16'd1;
    runt_next = (len_next < 16'(MIN_LEN));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fill       <= 3'd0;
      hold       <= '0;
      crc        <= CRC_INIT;
      len        <= 16'd0;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_good <= 1'b0;
      frame_runt <= 1'b0;
      frame_len  <= 16'd0;
    end else begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        hold <= {hold[2:0], in_data};
        if (state == STREAM) begin
          out_valid <= 1'b1;
          out_data  <= hold[3];
          out_last  <= in_last;
        end
        if (in_last) begin
          frame_done <= 1'b1;
          frame_good <= !runt_next && (crc_next == CRC_RESIDUE);
          frame_runt <= runt_next;
          frame_len  <= len_next;
          state      <= IDLE;
          fill       <= 3'd0;
          hold       <= '0;
          crc        <= CRC_INIT;
          len        <= 16'd0;
        end else begin
          crc <= crc_next;
          len <= len_next;
          case (state)
            IDLE: begin
              state <= FILL;
              fill  <= 3'd1;
            end
            FILL: begin
              fill <= fill + 3'd1;
              if (fill == 3'd3) state <= STREAM;
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef FCS_RX_STATS_EN
  // Counters follow the registered status, so they move one cycle after frame_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      good_count <= 16'd0;
      bad_count  <= 16'd0;
      runt_count <= 16'd0;
    end else if (frame_done) begin
      if (frame_good) begin
        if (good_count != 16'hFFFF) good_count <= good_count + 16'd1;
      end else if (frame_runt) begin
        if (runt_count != 16'hFFFF) runt_count <= runt_count + 16'd1;
      end else begin
        if (bad_count != 16'hFFFF) bad_count <= bad_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_eth_fcs_rx_check.sv
// Randomized self-checking bench for eth_fcs_rx_check against a queue-based frame model.
module tb_eth_fcs_rx_check;
  localparam int MIN_LEN = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        frame_done;
  logic        frame_good;
  logic        frame_runt;
  logic [15:0] frame_len;
`ifdef FCS_RX_STATS_EN
  logic [15:0] good_count, bad_count, runt_count;
  int m_gc, m_bc, m_rc;
`endif

  eth_fcs_rx_check #(.MIN_LEN(MIN_LEN)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .frame_done(frame_done), .frame_good(frame_good),
    .frame_runt(frame_runt), .frame_len(frame_len)
`ifdef FCS_RX_STATS_EN
    , .good_count(good_count), .bad_count(bad_count), .runt_count(runt_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [7:0]  mbuf[$];
  logic [7:0]  mframe[$];
  int          mlen;
  logic [7:0]  m_od;
  logic        m_good, m_runt;
  logic [15:0] m_len;

  // Standard Ethernet FCS of the first n bytes (init all-ones, final inversion).
  function automatic logic [31:0] ref_fcs(input logic [7:0] q[$], input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ q[k][b]) c = (c >> 1) ^ 32'hEDB8_8320;
        else c = c >> 1;
      end
    end
    return ~c;
  endfunction

  function automatic logic fcs_ok(input logic [7:0] f[$]);
    int n = f.size();
    if (n < 5) return 1'b0;
    return {f[n-1], f[n-2], f[n-3], f[n-4]} == ref_fcs(f, n - 4);
  endfunction

  task automatic compare_outputs(input logic exp_ov, input logic exp_ol, input logic exp_fd);
    check("out_valid", out_valid, exp_ov);
    check("out_data", out_data, m_od);
    check("out_last", out_last, exp_ol);
    check("frame_done", frame_done, exp_fd);
    check("frame_good", frame_good, m_good);
    check("frame_runt", frame_runt, m_runt);
    check("frame_len", frame_len, m_len);
`ifdef FCS_RX_STATS_EN
    check("good_count", good_count, m_gc);
    check("bad_count", bad_count, m_bc);
    check("runt_count", runt_count, m_rc);
    if (exp_fd) begin
      if (m_good) m_gc++;
      else if (m_runt) m_rc++;
      else m_bc++;
    end
`endif
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic l);
    logic exp_ov = 1'b0, exp_ol = 1'b0, exp_fd = 1'b0;
    in_valid = v; in_data = d; in_last = l;
    if (v) begin
      mbuf.push_back(d);
      mframe.push_back(d);
      if (mlen < 65535) mlen++;
      if (mbuf.size() > 4) begin
        m_od   = mbuf.pop_front();
        exp_ov = 1'b1;
        exp_ol = l;
      end
      if (l) begin
        exp_fd = 1'b1;
        m_len  = 16'(mlen);
        m_runt = (mlen < MIN_LEN);
        m_good = !m_runt && fcs_ok(mframe);
        mbuf.delete(); mframe.delete(); mlen = 0;
      end
    end
    @(posedge clk); #1;
    compare_outputs(exp_ov, exp_ol, exp_fd);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    mbuf.delete(); mframe.delete(); mlen = 0;
    m_od = 8'h00; m_good = 1'b0; m_runt = 1'b0; m_len = 16'd0;
`ifdef FCS_RX_STATS_EN
    m_gc = 0; m_bc = 0; m_rc = 0;
`endif
    compare_outputs(1'b0, 1'b0, 1'b0);
  endtask

  // gap_mode: 0 continuous, 1 idle cycle before every byte after the first, 2 random idles
  task automatic send_frame(input logic [7:0] f[$], input int gap_mode);
    for (int i = 0; i < f.size(); i++) begin
      if (gap_mode == 1 && i > 0) step(1'b0, 8'h00, 1'b0);
      if (gap_mode == 2) while ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom), 1'b0);
      step(1'b1, f[i], i == f.size() - 1);
    end
  endtask

  task automatic make_frame(input int n, input bit corrupt, output logic [7:0] f[$]);
    logic [31:0] fcs;
    int pos;
    f.delete();
    if (n < 5) begin
      for (int i = 0; i < n; i++) f.push_back(8'($urandom));
    end else begin
      for (int i = 0; i < n - 4; i++) f.push_back(8'($urandom));
      fcs = ref_fcs(f, n - 4);
      for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
      if (corrupt) begin
        pos = $urandom_range(0, n - 1);
        f[pos] = f[pos] ^ (8'h01 << $urandom_range(0, 7));
      end
    end
  endtask

  logic [7:0] good_f[$];
  logic [7:0] bad_f[$];
  logic [7:0] runt_f[$];
  logic [7:0] rnd_f[$];

  initial begin
    good_f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
    bad_f  = good_f;
    bad_f[12] = 8'hCA;
    runt_f = '{8'h00, 8'h00, 8'h00, 8'h00};

    do_reset();
    send_frame(good_f, 0);
    check("directed_good", frame_good, 1'b1);
    check("directed_good_len", frame_len, 16'd13);
    step(1'b0, 8'h00, 1'b0);
    send_frame(bad_f, 0);
    check("directed_bad", frame_good, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    send_frame(runt_f, 0);
    check("directed_runt", frame_runt, 1'b1);
    check("directed_runt_len", frame_len, 16'd4);
    step(1'b0, 8'h00, 1'b0);

    send_frame(good_f, 1);
    send_frame(bad_f, 1);
    step(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 6; i++) step(1'b1, good_f[i], 1'b0);
    do_reset();
    send_frame(good_f, 0);
    check("after_reset_good", frame_good, 1'b1);
    check("after_reset_len", frame_len, 16'd13);
    step(1'b0, 8'h00, 1'b0);

    // Length boundaries around 4/5 and MIN_LEN
    for (int n = 1; n <= MIN_LEN + 2; n++) begin
      make_frame(n, 1'b0, rnd_f);
      send_frame(rnd_f, 0);
    end
    step(1'b0, 8'h00, 1'b0);

    for (int t = 0; t < 60; t++) begin
      make_frame($urandom_range(1, 24), $urandom_range(0, 2) == 0, rnd_f);
      send_frame(rnd_f, 2);
    end
    step(1'b0, 8'h00, 1'b0);

    do_reset();
    send_frame(good_f, 0);
    send_frame(bad_f, 0);
    send_frame(runt_f, 0);
    send_frame(good_f, 0);
    step(1'b0, 8'h00, 1'b0);
`ifdef FCS_RX_STATS_EN
    check("stats_good", good_count, 16'd2);
    check("stats_bad", bad_count, 16'd1);
    check("stats_runt", runt_count, 16'd1);
`endif
    step(1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
